// File: rtl/spi_stim_pkg.sv
// Shared encodings, default LFSR taps and a saturating counter helper
// for the SPI stimulus generator.
package spi_stim_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_FIXED = 2'd2,
        MODE_WALK  = 2'd3
    } stim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } stim_state_e;

    localparam logic [47:0] DEFAULT_LFSR_POLY = 48'hB4_0000_0000_01;
    localparam int          CNT_WIDTH         = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/stim_exp_fifo.sv
// Expected-data FIFO: holds issued words until the matching slave frame returns.
// A pop in the same cycle as a push frees the slot, so push is accepted even when full.
module stim_exp_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_stim_gen.sv
// Stimulus generator and loopback checker for the bidirectional SPI controller.
// Issues patterned write frames at a fixed spacing and scores returned slave frames.
module spi_stim_gen
    import spi_stim_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 48,
    parameter int                    RX_WIDTH     = 64,
    parameter int                    PERIOD_WIDTH = 16,
    parameter int                    EXP_DEPTH    = 4,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY    = DATA_WIDTH'(DEFAULT_LFSR_POLY)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic [1:0]              mode_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [15:0]             burst_len_i,
    input  logic [DATA_WIDTH-1:0]   seed_i,
    input  logic                    wr_busy_i,
    output logic                    wr_en_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    input  logic                    rx_vld_i,
    input  logic [RX_WIDTH-1:0]     rx_data_i,
    output logic [15:0]             tx_count_o,
    output logic [15:0]             rx_count_o,
    output logic [15:0]             err_count_o,
    output logic                    done_o
);

    logic [1:0]              rst_sync_q, rst_sync_d;
    logic                    rst_n;

    stim_state_e             state_q, state_d;
    stim_mode_e              mode_q, mode_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [15:0]             burst_q, burst_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
    logic [15:0]             tx_count_q, tx_count_d;
    logic [15:0]             rx_count_q, rx_count_d;
    logic [15:0]             err_count_q, err_count_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    done_q, done_d;

    logic [PERIOD_WIDTH-1:0] period_last;
    logic [DATA_WIDTH-1:0]   pattern_init;
    logic [DATA_WIDTH-1:0]   pattern_next;
    logic                    fifo_push, fifo_pop, fifo_flush;
    logic                    fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_head;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    generate
        if (RX_WIDTH > DATA_WIDTH) begin : g_rx_hi
            logic unused_rx_hi;
            assign unused_rx_hi = ^rx_data_i[RX_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    assign period_last = ((period_q == '0) ? PERIOD_WIDTH'(1) : period_q) - PERIOD_WIDTH'(1);

    always_comb begin
        case (stim_mode_e'(mode_i))
            MODE_LFSR: pattern_init = (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
            MODE_WALK: pattern_init = DATA_WIDTH'(1);
            default:   pattern_init = seed_i;
        endcase
    end

    always_comb begin
        case (mode_q)
            MODE_INC:   pattern_next = pattern_q + DATA_WIDTH'(1);
            MODE_LFSR:  pattern_next = (pattern_q >> 1) ^ (pattern_q[0] ? LFSR_POLY : '0);
            MODE_WALK:  pattern_next = {pattern_q[DATA_WIDTH-2:0], pattern_q[DATA_WIDTH-1]};
            default:    pattern_next = pattern_q;
        endcase
    end

    // Sequencer: idle -> period count -> issue (stall on busy/full) -> repeat or done.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        pattern_d  = pattern_q;
        tx_count_d = tx_count_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (!enable_i) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mode_d     = stim_mode_e'(mode_i);
                    period_d   = period_i;
                    burst_d    = burst_len_i;
                    pattern_d  = pattern_init;
                    tx_count_d = '0;
                    cnt_d      = '0;
                    fifo_flush = 1'b1;
                    state_d    = ST_COUNT;
                end
                ST_COUNT: begin
                    if (cnt_q == period_last) begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        cnt_d = cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                ST_ISSUE: begin
                    if (!wr_busy_i && !fifo_full) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = pattern_q;
                        fifo_push  = 1'b1;
                        pattern_d  = pattern_next;
                        tx_count_d = sat_inc(tx_count_q);
                        cnt_d      = '0;
                        if (burst_q != '0 && tx_count_d == burst_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Loopback checker: every returned frame consumes one expected word if available.
    always_comb begin
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        fifo_pop    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable_i) begin
                rx_count_d  = '0;
                err_count_d = '0;
            end
        end else if (rx_vld_i) begin
            rx_count_d = sat_inc(rx_count_q);
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (rx_data_i[DATA_WIDTH-1:0] != fifo_head) begin
                    err_count_d = sat_inc(err_count_q);
                end
            end else begin
                err_count_d = sat_inc(err_count_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_INC;
            period_q    <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            pattern_q   <= '0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            pattern_q   <= pattern_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    stim_exp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (pattern_q),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign tx_count_o  = tx_count_q;
    assign rx_count_o  = rx_count_q;
    assign err_count_o = err_count_q;
    assign done_o      = done_q;

endmodule
